// File: rtl/uart_cmd_rx_if.sv
// ---------------------------------------------------------------------------
// uart_cmd_rx_if
//
// Signal bundle between the host-link serial line and the command receiver.
//
//   rx           serial line into the receiver (idles high, asynchronous)
//   rx_data      last correctly framed byte
//   new_rx_data  one-cycle strobe, rx_data has just taken a new byte
//   frame_err    one-cycle strobe, stop bit sampled low
//   busy         receiver is somewhere other than IDLE
//
// Modports:
//   master  drives the line and observes the receiver outputs
//   slave   the receiver itself
// ---------------------------------------------------------------------------
interface uart_cmd_rx_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       new_rx_data;
  logic       frame_err;
  logic       busy;

  modport master (
    output rx,
    input  rx_data,
    input  new_rx_data,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  rx,
    output rx_data,
    output new_rx_data,
    output frame_err,
    output busy
  );
endinterface

// File: rtl/uart_cmd_rx.sv
// ---------------------------------------------------------------------------
// uart_cmd_rx
//
// 8N1 UART receiver (LSB first) for the host command link. Good bytes appear
// on rx_data together with a one-cycle new_rx_data strobe; a low stop bit
// gives a one-cycle frame_err strobe instead. A start bit that is no longer
// low at its centre is treated as a glitch and dropped silently.
//
// Parameters:
//   CLK_PER_BIT  clock cycles per serial bit (>= 8), default 100
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous reset, active low
//   bus   uart_cmd_rx_if.slave (rx in; rx_data, new_rx_data, frame_err,
//         busy out)
//
// Build option:
//   UART_RX_MAJORITY_EN  when defined, each bit is the 2-of-3 majority of the
//                        synchronised line at centre-1, centre and centre+1,
//                        decided at centre+1. Every decision point and strobe
//                        moves one cycle later; nothing else changes.
// ---------------------------------------------------------------------------
module uart_cmd_rx #(
  parameter int CLK_PER_BIT = 100
) (
  input  logic         clk,
  input  logic         rst,
  uart_cmd_rx_if.slave bus
);

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam int C  = CLK_PER_BIT / 2;

  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  // -------------------------------------------------------------------------
  // Two-flop synchroniser; resets to the idle (high) line level so a reset
  // never looks like a start edge.
  // -------------------------------------------------------------------------
  logic [1:0] sync_reg;
  logic       rx_s;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], bus.rx};
    end
  end

  assign rx_s = sync_reg[1];

  // -------------------------------------------------------------------------
  // Bit sample and its decision offset inside a bit period.
  // -------------------------------------------------------------------------
  logic sample;

`ifdef UART_RX_MAJORITY_EN
  localparam int DEC_OFS = C + 1;

  // hist_reg[0] holds rx_s from one cycle ago, hist_reg[1] from two cycles
  // ago, so at offset C+1 the three votes are at C-1, C and C+1.
  logic [1:0] hist_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      hist_reg <= 2'b11;
    end else begin
      hist_reg <= {hist_reg[0], rx_s};
    end
  end

  assign sample = (rx_s & hist_reg[0]) | (rx_s & hist_reg[1]) |
                  (hist_reg[0] & hist_reg[1]);
`else
  localparam int DEC_OFS = C;

  assign sample = rx_s;
`endif

  localparam logic [CW-1:0] DEC_CNT = CW'(DEC_OFS);

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  state_t      state_reg,       state_next;
  logic [CW-1:0] cnt_reg,       cnt_next;
  logic [2:0]  bit_idx_reg,     bit_idx_next;
  logic [7:0]  shift_reg,       shift_next;
  logic        stop_done_reg,   stop_done_next;
  logic        stop_bit_reg,    stop_bit_next;
  logic [7:0]  rx_data_reg,     rx_data_next;
  logic        new_rx_data_reg, new_rx_data_next;
  logic        frame_err_reg,   frame_err_next;

  logic          decide;
  logic [CW-1:0] cnt_adv;

  // The counter is loaded with 1 on the IDLE->START edge, so inside a frame
  // it equals the cycle offset within the current bit; the decision point is
  // therefore a plain compare against the offset.
  assign decide  = (cnt_reg == DEC_CNT);
  assign cnt_adv = (cnt_reg == CNT_MAX) ? '0 : cnt_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      bit_idx_reg     <= '0;
      shift_reg       <= '0;
      stop_done_reg   <= 1'b0;
      stop_bit_reg    <= 1'b0;
      rx_data_reg     <= 8'h00;
      new_rx_data_reg <= 1'b0;
      frame_err_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      bit_idx_reg     <= bit_idx_next;
      shift_reg       <= shift_next;
      stop_done_reg   <= stop_done_next;
      stop_bit_reg    <= stop_bit_next;
      rx_data_reg     <= rx_data_next;
      new_rx_data_reg <= new_rx_data_next;
      frame_err_reg   <= frame_err_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    bit_idx_next     = bit_idx_reg;
    shift_next       = shift_reg;
    stop_done_next   = stop_done_reg;
    stop_bit_next    = stop_bit_reg;
    rx_data_next     = rx_data_reg;
    new_rx_data_next = 1'b0;
    frame_err_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        cnt_next       = '0;
        bit_idx_next   = '0;
        stop_done_next = 1'b0;
        if (!rx_s) begin
          state_next = START;
          cnt_next   = CW'(1);
        end
      end

      START: begin
        cnt_next = cnt_adv;
        if (decide) begin
          if (sample) begin
            // Line went back high before the start-bit centre: glitch.
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            state_next   = DATA;
            bit_idx_next = '0;
          end
        end
      end

      DATA: begin
        cnt_next = cnt_adv;
        if (decide) begin
          shift_next   = {sample, shift_reg[7:1]};
          bit_idx_next = bit_idx_reg + 1'b1;
          if (bit_idx_reg == 3'd7) begin
            state_next = STOP;
          end
        end
      end

      STOP: begin
        cnt_next = cnt_adv;
        // The stop sample is captured at the decision point; the strobe and
        // the state change follow on the next edge so both are registered.
        // Leaving STOP here (mid stop bit) is what lets a back-to-back start
        // edge be caught at the very next IDLE cycle.
        if (stop_done_reg) begin
          stop_done_next = 1'b0;
          cnt_next       = '0;
          if (stop_bit_reg) begin
            rx_data_next     = shift_reg;
            new_rx_data_next = 1'b1;
            state_next       = IDLE;
          end else begin
            frame_err_next = 1'b1;
            state_next     = WAIT_IDLE;
          end
        end else if (decide) begin
          stop_done_next = 1'b1;
          stop_bit_next  = sample;
        end
      end

      WAIT_IDLE: begin
        // Hold here through a break so it reports only one frame error.
        cnt_next = '0;
        if (rx_s) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign bus.rx_data     = rx_data_reg;
  assign bus.new_rx_data = new_rx_data_reg;
  assign bus.frame_err   = frame_err_reg;
  assign bus.busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_cmd_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_rx
//
// Directed bench for uart_cmd_rx at CLK_PER_BIT=100. Drives serial frames on
// the interface, records every strobe with its cycle number and checks data,
// latency, spacing, glitch rejection, framing errors, mid-frame reset and
// (build dependent) the majority-vote spike filter.
// ---------------------------------------------------------------------------
module tb_uart_cmd_rx;

  localparam int CPB = 100;
  localparam int C   = CPB / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  uart_cmd_rx_if bus_if ();

  uart_cmd_rx #(
    .CLK_PER_BIT(CPB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Strobe monitor, sampled on the falling edge
  // -------------------------------------------------------------------------
  int         st_cyc[$];
  logic [7:0] st_dat[$];
  int         ferr_cnt  = 0;
  logic       prev_new  = 1'b0;
  logic       prev_ferr = 1'b0;

  always @(negedge clk) begin
    if (bus_if.new_rx_data || bus_if.frame_err)
      check("strobe_excl", 32'(bus_if.new_rx_data & bus_if.frame_err), 0);
    if (bus_if.new_rx_data) begin
      check("new_single", 32'(prev_new), 0);
      st_cyc.push_back(cyc);
      st_dat.push_back(bus_if.rx_data);
      $display("rx byte %02h at cycle %0d", bus_if.rx_data, cyc);
    end
    if (bus_if.frame_err) begin
      check("ferr_single", 32'(prev_ferr), 0);
      ferr_cnt++;
      $display("frame error at cycle %0d", cyc);
    end
    prev_new  = bus_if.new_rx_data;
    prev_ferr = bus_if.frame_err;
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers; every helper returns 1 time unit after a rising edge
  // -------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends start, 8 data bits LSB first and the given stop level. If
  // spike_bit selects a frame bit (0..9), a one-cycle inverted spike is put
  // exactly on that bit's centre sample. start is the cycle number of the
  // first edge that samples the start bit.
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input int spike_bit, output int start);
    logic [9:0] bits;
    bits  = {stop, d, 1'b0};
    start = cyc + 1;
    for (int n = 0; n < 10; n++) begin
      bus_if.rx = bits[n];
      if (n == spike_bit) begin
        tick(C);
        bus_if.rx = ~bits[n];
        tick(1);
        bus_if.rx = bits[n];
        tick(CPB - C - 1);
      end else begin
        tick(CPB);
      end
    end
  endtask

  task automatic expect_one(input string tag, input logic [7:0] d,
                            input int start);
    check({tag, "_count"}, st_cyc.size(), 1);
    if (st_cyc.size() >= 1) begin
      check({tag, "_data"}, 32'(st_dat[0]), 32'(d));
      check({tag, "_lat"}, st_cyc[0] - start, 953 + MAJ);
    end
    check({tag, "_rx_data"}, 32'(bus_if.rx_data), 32'(d));
    st_cyc.delete();
    st_dat.delete();
  endtask

  // -------------------------------------------------------------------------
  // Test sequence
  // -------------------------------------------------------------------------
  initial begin
    int s0, s1, s2, f0;
    bus_if.rx = 1'b1;
    rst       = 1'b0;
    tick(4);
    check("rst_rx_data", 32'(bus_if.rx_data), 0);
    check("rst_new", 32'(bus_if.new_rx_data), 0);
    check("rst_ferr", 32'(bus_if.frame_err), 0);
    check("rst_busy", 32'(bus_if.busy), 0);
    rst = 1'b1;
    tick(10);

    // Single byte: data and latency
    send_frame(8'h64, 1'b1, -1, s0);
    tick(20);
    expect_one("b64", 8'h64, s0);
    check("b64_busy_idle", 32'(bus_if.busy), 0);

    // Back-to-back frames, one stop bit each
    send_frame(8'h68, 1'b1, -1, s0);
    send_frame(8'h00, 1'b1, -1, s1);
    send_frame(8'hFF, 1'b1, -1, s2);
    tick(20);
    check("b2b_count", st_cyc.size(), 3);
    if (st_cyc.size() == 3) begin
      check("b2b_d0", 32'(st_dat[0]), 32'h68);
      check("b2b_d1", 32'(st_dat[1]), 32'h00);
      check("b2b_d2", 32'(st_dat[2]), 32'hFF);
      check("b2b_gap01", st_cyc[1] - st_cyc[0], 1000);
      check("b2b_gap12", st_cyc[2] - st_cyc[1], 1000);
      check("b2b_lat0", st_cyc[0] - s0, 953 + MAJ);
    end
    st_cyc.delete();
    st_dat.delete();

    // Start glitch: 30 cycles low
    f0        = ferr_cnt;
    bus_if.rx = 1'b0;
    s0        = cyc + 1;
    tick(30);
    bus_if.rx = 1'b1;
    check("glitch_busy_on", 32'(bus_if.busy), 1);
    tick(51 + MAJ - (cyc - s0));
    check("glitch_busy_before_drop", 32'(bus_if.busy), 1);
    tick(1);
    check("glitch_busy_clear", 32'(bus_if.busy), 0);
    tick(2 * CPB);
    check("glitch_no_strobe", st_cyc.size(), 0);
    check("glitch_no_ferr", ferr_cnt - f0, 0);
    send_frame(8'hA5, 1'b1, -1, s0);
    tick(20);
    expect_one("bA5", 8'hA5, s0);

    // Stop bit low, then a 2000-cycle break
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, -1, s0);
    tick(2000);
    check("break_busy", 32'(bus_if.busy), 1);
    bus_if.rx = 1'b1;
    tick(3 * CPB);
    check("break_ferr_count", ferr_cnt - f0, 1);
    check("break_no_strobe", st_cyc.size(), 0);
    check("break_rx_data_kept", 32'(bus_if.rx_data), 32'hA5);
    check("break_busy_clear", 32'(bus_if.busy), 0);
    send_frame(8'h11, 1'b1, -1, s0);
    tick(20);
    expect_one("b11", 8'h11, s0);

    // Reset in the middle of data bit 4 of 8'h55
    f0        = ferr_cnt;
    bus_if.rx = 1'b0;
    tick(CPB);
    bus_if.rx = 1'b1;           // d0
    tick(CPB);
    bus_if.rx = 1'b0;           // d1
    tick(CPB);
    bus_if.rx = 1'b1;           // d2
    tick(CPB);
    bus_if.rx = 1'b0;           // d3
    tick(C);
    check("mid_busy", 32'(bus_if.busy), 1);
    rst       = 1'b0;
    bus_if.rx = 1'b1;
    tick(1);
    rst = 1'b1;
    check("mid_rst_rx_data", 32'(bus_if.rx_data), 0);
    check("mid_rst_new", 32'(bus_if.new_rx_data), 0);
    check("mid_rst_ferr", 32'(bus_if.frame_err), 0);
    check("mid_rst_busy", 32'(bus_if.busy), 0);
    tick(3 * CPB);
    check("mid_no_strobe", st_cyc.size(), 0);
    check("mid_no_ferr", ferr_cnt - f0, 0);
    send_frame(8'h2A, 1'b1, -1, s0);
    tick(20);
    expect_one("b2A", 8'h2A, s0);

    // One-cycle spike on the centre of data bit 3 (frame bit 4) of 8'h00
    send_frame(8'h00, 1'b1, 4, s0);
    tick(20);
    expect_one("spike", (MAJ != 0) ? 8'h00 : 8'h08, s0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_rx.md
# uart_cmd_rx

- Serial receiver for the host command link: 8N1 UART frames, LSB first.
- Emits each good byte as `rx_data` with a one-cycle `new_rx_data` strobe. These feed the TDC/motion command controller directly.
- Reports framing errors and rejects start-bit glitches.
- Input is asynchronous to `clk` and is synchronised internally.

## Interface
- `CLK_PER_BIT`, default 100: clock cycles per bit (50 MHz / 500 kbaud). Must be ≥ 8. Counter width is $clog2(CLK_PER_BIT).
- `clk`  in  1: system clock. All logic is on the rising edge.
- `rst`  in  1: synchronous reset, active-low. Sampled on the rising edge of `clk`.
- `rx`  in  1: asynchronous serial line. Idles high.
- `rx_data`  out  8: last correctly framed byte. Holds its value until the next good byte.
- `new_rx_data`  out  1: one-cycle pulse, high in the cycle `rx_data` first shows a new byte.
- `frame_err`  out  1: one-cycle pulse when the stop bit samples low.
- `busy`  out  1: high in every state except IDLE.

## Operation
- Synchroniser: two flip-flops from `rx` to `rx_s`. Both reset to 1.
- States: IDLE, START, DATA, STOP, WAIT_IDLE.
- Bit timing:
  - T0 is the cycle in which IDLE sees `rx_s`=0.
  - Bit n (start=0, data 1..8, stop=9) begins at T0+n·CLK_PER_BIT.
  - Centre offset C = CLK_PER_BIT/2 (integer division).
  - The sample decision is made at bit start + C (+1 with majority, see Configuration).
- IDLE:
  - `rx_s`=0: go to START, load bit counter with 1.
  - Otherwise stay.
- START, at decision:
  - Sample 0: go to DATA.
  - Sample 1: glitch. Go to IDLE with no output pulse.
- DATA:
  - At each decision, shift the sample into the byte, LSB first.
  - After bit 8: go to STOP.
- STOP, at decision:
  - Sample 1: next cycle `rx_data` ← byte and `new_rx_data`=1. Go to IDLE immediately, without waiting for the end of the stop bit.
  - Sample 0: next cycle `frame_err`=1. `rx_data` is unchanged. Go to WAIT_IDLE.
- WAIT_IDLE: stay until `rx_s`=1, then go to IDLE. A held-low break therefore gives exactly one `frame_err`.
- Exclusivity:
  - `new_rx_data` and `frame_err` are never high in the same cycle.
  - Neither strobe is ever high for two consecutive cycles.
- Back-to-back frames: a start edge seen in the IDLE cycle right after the stop decision is accepted. No gap beyond the remaining half stop bit is required.

## Timing
- Reset values: `rx_data`=8'h00, `new_rx_data`=0, `frame_err`=0, `busy`=0, state IDLE, counters 0.
- Reset mid-frame:
  - Go to IDLE next cycle.
  - The partial byte is discarded and no strobe is issued.
  - `rx_data` returns to 8'h00.
- Latency, from the first clock edge that samples `rx` low to `new_rx_data` high:
  - Without majority: 2 + 9·CLK_PER_BIT + C + 1 cycles.
  - CLK_PER_BIT=100: 953 cycles; 954 with majority.
- `busy` rises the cycle after T0. It falls in the cycle the strobe is issued, or when WAIT_IDLE exits.
- Baud tolerance: the stop bit is sampled at its centre, so roughly ±4.5 % total mismatch is tolerated.

## Configuration
- `UART_RX_MAJORITY_EN`
  - Defined: each bit takes three `rx_s` samples, at offsets C−1, C and C+1. The decision is their 2-of-3 majority, made at C+1. All decision points and strobes move one cycle later.
  - Undefined: a single sample at offset C is the decision.
  - All other behaviour is identical in both builds.

## Test plan
- Byte 8'h64 ("d") at CLK_PER_BIT=100:
  - `rx_data`=8'h64 and a single `new_rx_data` pulse.
  - Pulse arrives 953 cycles after the start edge; 954 cycles with `UART_RX_MAJORITY_EN`.
- Bytes 8'h68, 8'h00, 8'hFF sent back to back with one stop bit each: three strobes, in order, spaced exactly 1000 cycles apart.
- Start glitch: `rx` low for 30 cycles, then high:
  - No strobe and no `frame_err`.
  - `busy` clears by cycle 52 of the glitch.
  - A following valid 8'hA5 is received correctly.
- Stop bit forced low on 8'h3C, then line held low for 2000 cycles, then released:
  - Exactly one `frame_err` pulse.
  - `rx_data` keeps its previous value.
  - Next frame 8'h11 is received.
- `rst`=0 for one cycle during data bit 4 of 8'h55:
  - All outputs go to reset values.
  - No strobe for the aborted frame.
  - The next full frame 8'h2A is received.
- `UART_RX_MAJORITY_EN` build: a one-cycle high spike at the centre of a 0 data bit in 8'h00 still yields 8'h00. The single-sample build yields a corrupted byte.
